// File: rtl/rob_multi_commit_pkg.sv
// Shared constants for the multi-commit reorder buffer: instruction type
// codes, the default entry-count width and small type classifiers.
package rob_multi_commit_pkg;

    localparam int ROB_ADDR_W_DEFAULT = 3;

    typedef enum logic [2:0] {
        TYPE_TOREG  = 3'd0,
        TYPE_LOAD   = 3'd1,
        TYPE_STORE  = 3'd2,
        TYPE_BRANCH = 3'd3,
        TYPE_JUMP   = 3'd4,
        TYPE_EXIT   = 3'd5
    } rob_type_e;

    // Types whose commit writes the register file (jumps write the link).
    function automatic logic writes_rf(input logic [2:0] t);
        return (t == TYPE_TOREG) || (t == TYPE_LOAD) || (t == TYPE_JUMP);
    endfunction

    // Types that may only commit alone from slot 0.
    function automatic logic solo_commit(input logic [2:0] t);
        return (t == TYPE_STORE) || (t == TYPE_BRANCH) ||
               (t == TYPE_JUMP)  || (t == TYPE_EXIT);
    endfunction

endpackage

// File: rtl/rob_multi_commit_query_bypass.sv
// One operand query: entry ready bit/value, bypassed from the writeback
// ports when the entry completes in this very cycle.
module rob_query_bypass #(
    parameter int ADDR_W = 3,
    parameter int NUM_WB = 2
) (
    input  logic [ADDR_W-1:0]        q_id,
    input  logic                     entry_ready,
    input  logic [31:0]              entry_value,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*ADDR_W-1:0] wb_id,
    input  logic [NUM_WB*32-1:0]     wb_value,
    output logic                     q_ready,
    output logic [31:0]              q_value
);

    logic        wb_hit;
    logic [31:0] wb_hit_value;

    // Scan ports from highest to lowest so the lowest matching port wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wb_hit       = 1'b0;
        wb_hit_value = 32'd0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_id[p*ADDR_W +: ADDR_W] == q_id)) begin
                wb_hit       = 1'b1;
                wb_hit_value = wb_value[p*32 +: 32];
            end
        end
    end

    assign q_ready = entry_ready | wb_hit;
    assign q_value = entry_ready ? entry_value : (wb_hit ? wb_hit_value : 32'd0);

endmodule

// File: rtl/rob_multi_commit.sv
// Parametrised reorder buffer: in-order issue, NUM_WB writeback ports,
// up to two in-order commits per cycle, registered flush/branch/exit pulses.
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int ADDR_W   = ROB_ADDR_W_DEFAULT,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       iss_valid,
    input  logic                       iss_done,
    input  logic [2:0]                 iss_type,
    input  logic                       iss_is_jalr,
    input  logic [4:0]                 iss_rd,
    input  logic [31:0]                iss_value,
    input  logic [31:0]                iss_pc,
    input  logic [31:0]                iss_target,
    input  logic                       iss_pred_taken,
    output logic [ADDR_W-1:0]          iss_id,
    output logic                       rob_full,
    output logic                       rob_empty,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*ADDR_W-1:0]   wb_id,
    input  logic [NUM_WB*32-1:0]       wb_value,
    input  logic [2*ADDR_W-1:0]        q_id,
    output logic [1:0]                 q_ready,
    output logic [63:0]                q_value,
    output logic [COMMIT_W-1:0]        cm_valid,
    output logic [COMMIT_W-1:0]        cm_wr,
    output logic [COMMIT_W*5-1:0]      cm_rd,
    output logic [COMMIT_W*ADDR_W-1:0] cm_id,
    output logic [COMMIT_W*32-1:0]     cm_value,
    output logic                       lsb_head_valid,
    output logic [ADDR_W-1:0]          lsb_head_id,
    output logic                       flush_out,
    output logic [31:0]                flush_pc,
    output logic                       bp_valid,
    output logic [31:0]                bp_pc,
    output logic                       bp_taken,
    output logic                       exit_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0]   count;
    logic [DEPTH-1:0]  busy, ready, e_jalr, e_pred;
    logic [2:0]        e_type   [DEPTH];
    logic [4:0]        e_rd     [DEPTH];
    logic [31:0]       e_value  [DEPTH];
    logic [31:0]       e_pc     [DEPTH];
    logic [31:0]       e_target [DEPTH];

    logic              live, issue_fire, pair_ok, head_taken;
    logic [1:0]        commit_fire, ncommit;
    logic [ADDR_W-1:0] slot_id [2];

    assign rob_full    = (count == FULL_COUNT);
    assign rob_empty   = (count == '0);
    assign iss_id      = tail;
    assign lsb_head_id = head;
    assign lsb_head_valid = !rob_empty &&
                            ((e_type[head] == TYPE_LOAD) || (e_type[head] == TYPE_STORE));

    // A pending flush makes this cycle behave as reset for issue/writeback/commit.
    assign live       = rdy_in & ~flush_out;
    assign issue_fire = live & iss_valid & ~rob_full;

    assign slot_id[0] = head;
    assign slot_id[1] = head + ADDR_W'(1);

    assign pair_ok = busy[slot_id[1]] & ready[slot_id[1]] &
                     ~solo_commit(e_type[slot_id[0]]) & ~solo_commit(e_type[slot_id[1]]);

    assign commit_fire[0] = live & busy[head] & ready[head];
    assign commit_fire[1] = (COMMIT_W == 2) && commit_fire[0] && pair_ok;
    assign ncommit        = {1'b0, commit_fire[0]} + {1'b0, commit_fire[1]};
    assign head_taken     = (e_value[head] != 32'd0);

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_cm
        assign cm_valid[k]               = commit_fire[k];
        assign cm_wr[k]                  = commit_fire[k] & writes_rf(e_type[slot_id[k]]);
        assign cm_rd[k*5 +: 5]           = e_rd[slot_id[k]];
        assign cm_id[k*ADDR_W +: ADDR_W] = slot_id[k];
        assign cm_value[k*32 +: 32]      = e_value[slot_id[k]];
    end

    for (genvar j = 0; j < 2; j++) begin : g_query
        rob_query_bypass #(
            .ADDR_W (ADDR_W),
            .NUM_WB (NUM_WB)
        ) u_query (
            .q_id        (q_id[j*ADDR_W +: ADDR_W]),
            .entry_ready (ready[q_id[j*ADDR_W +: ADDR_W]]),
            .entry_value (e_value[q_id[j*ADDR_W +: ADDR_W]]),
            .wb_valid    (wb_valid),
            .wb_id       (wb_id),
            .wb_value    (wb_value),
            .q_ready     (q_ready[j]),
            .q_value     (q_value[j*32 +: 32])
        );
    end

    // Control state: pointers, occupancy, busy/ready bits and output pulses.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || (rdy_in && flush_out)) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            busy      <= '0;
            ready     <= '0;
            flush_out <= 1'b0;
            flush_pc  <= 32'd0;
            bp_valid  <= 1'b0;
            bp_pc     <= 32'd0;
            bp_taken  <= 1'b0;
            exit_out  <= 1'b0;
        end else if (rdy_in) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && busy[wb_id[p*ADDR_W +: ADDR_W]])
                    ready[wb_id[p*ADDR_W +: ADDR_W]] <= 1'b1;
            end
            // NOTE: non-blocking updates to the same bit later in this block override earlier ones.
            for (int k = 0; k < 2; k++) begin
                if (commit_fire[k]) begin
                    busy[slot_id[k]]  <= 1'b0;
                    ready[slot_id[k]] <= 1'b0;
                end
            end
            if (issue_fire) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= iss_done;
                tail        <= tail + ADDR_W'(1);
            end
            head  <= head + ADDR_W'(ncommit);
            count <= count + (ADDR_W+1)'(issue_fire) - (ADDR_W+1)'(ncommit);

            bp_valid  <= 1'b0;
            flush_out <= 1'b0;
            exit_out  <= 1'b0;
            if (commit_fire[0]) begin
                case (e_type[head])
                    TYPE_BRANCH: begin
                        bp_valid <= 1'b1;
                        bp_pc    <= e_pc[head];
                        bp_taken <= head_taken;
                        if (head_taken != e_pred[head]) begin
                            flush_out <= 1'b1;
                            flush_pc  <= head_taken ? e_target[head] : e_pc[head] + 32'd4;
                        end
                    end
                    TYPE_JUMP: begin
                        if (e_jalr[head]) begin
                            flush_out <= 1'b1;
                            flush_pc  <= e_target[head];
                        end
                    end
                    TYPE_EXIT: exit_out <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Entry payload: written at issue and by writeback, never reset.
    // NOTE: payload needs no reset because busy/ready gate every use of it.
    always_ff @(posedge clk_in) begin
        if (live) begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && busy[wb_id[p*ADDR_W +: ADDR_W]]) begin
                    if (e_jalr[wb_id[p*ADDR_W +: ADDR_W]])
                        e_target[wb_id[p*ADDR_W +: ADDR_W]] <= wb_value[p*32 +: 32];
                    else
                        e_value[wb_id[p*ADDR_W +: ADDR_W]]  <= wb_value[p*32 +: 32];
                end
            end
            if (issue_fire) begin
                e_type[tail]   <= iss_type;
                e_jalr[tail]   <= iss_is_jalr;
                e_rd[tail]     <= iss_rd;
                e_value[tail]  <= iss_value;
                e_pc[tail]     <= iss_pc;
                e_target[tail] <= iss_target;
                e_pred[tail]   <= iss_pred_taken;
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed scenarios followed by
// random traffic, all compared against an in-order queue model of the ROB.
module tb_rob_multi_commit;
    import rob_multi_commit_pkg::*;

    localparam int ADDR_W   = 3;
    localparam int NUM_WB   = 2;
    localparam int COMMIT_W = 2;
    localparam int DEPTH    = 8;

    logic                       clk_in = 1'b0;
    logic                       rst_n_in, rdy_in;
    logic                       iss_valid, iss_done, iss_is_jalr, iss_pred_taken;
    logic [2:0]                 iss_type;
    logic [4:0]                 iss_rd;
    logic [31:0]                iss_value, iss_pc, iss_target;
    logic [ADDR_W-1:0]          iss_id;
    logic                       rob_full, rob_empty;
    logic [NUM_WB-1:0]          wb_valid;
    logic [NUM_WB*ADDR_W-1:0]   wb_id;
    logic [NUM_WB*32-1:0]       wb_value;
    logic [2*ADDR_W-1:0]        q_id;
    logic [1:0]                 q_ready;
    logic [63:0]                q_value;
    logic [COMMIT_W-1:0]        cm_valid, cm_wr;
    logic [COMMIT_W*5-1:0]      cm_rd;
    logic [COMMIT_W*ADDR_W-1:0] cm_id;
    logic [COMMIT_W*32-1:0]     cm_value;
    logic                       lsb_head_valid;
    logic [ADDR_W-1:0]          lsb_head_id;
    logic                       flush_out, bp_valid, bp_taken, exit_out;
    logic [31:0]                flush_pc, bp_pc;

    rob_multi_commit #(.ADDR_W(ADDR_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .iss_valid(iss_valid), .iss_done(iss_done), .iss_type(iss_type),
        .iss_is_jalr(iss_is_jalr), .iss_rd(iss_rd), .iss_value(iss_value),
        .iss_pc(iss_pc), .iss_target(iss_target), .iss_pred_taken(iss_pred_taken),
        .iss_id(iss_id), .rob_full(rob_full), .rob_empty(rob_empty),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
        .cm_valid(cm_valid), .cm_wr(cm_wr), .cm_rd(cm_rd), .cm_id(cm_id),
        .cm_value(cm_value), .lsb_head_valid(lsb_head_valid), .lsb_head_id(lsb_head_id),
        .flush_out(flush_out), .flush_pc(flush_pc), .bp_valid(bp_valid),
        .bp_pc(bp_pc), .bp_taken(bp_taken), .exit_out(exit_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        logic [2:0]  typ;
        logic        jalr;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic        rdy;
        int          id;
    } ent_t;

    ent_t        mq[$];
    int          m_next_id;
    logic        m_flush, m_bp_valid, m_bp_taken, m_exit;
    logic [31:0] m_flush_pc, m_bp_pc;

    function automatic bit alone_only(input logic [2:0] t);
        return t inside {TYPE_STORE, TYPE_BRANCH, TYPE_JUMP, TYPE_EXIT};
    endfunction

    function automatic int m_ncommit();
        int n = 0;
        if (mq.size() > 0 && mq[0].rdy) begin
            n = 1;
            if (COMMIT_W == 2 && mq.size() > 1 && mq[1].rdy &&
                !alone_only(mq[0].typ) && !alone_only(mq[1].typ))
                n = 2;
        end
        return n;
    endfunction

    function automatic int m_find(input int id);
        foreach (mq[i]) if (mq[i].id == id) return i;
        return -1;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_next_id  = 0;
        m_flush    = 1'b0;
        m_flush_pc = 32'd0;
        m_bp_valid = 1'b0;
        m_bp_pc    = 32'd0;
        m_bp_taken = 1'b0;
        m_exit     = 1'b0;
    endtask

    task automatic check_outputs();
        int n, idx, qid;
        logic [1:0]  exp_valid;
        logic        sr, hit;
        logic [31:0] hv;
        check("rob_empty", rob_empty, mq.size() == 0);
        check("rob_full", rob_full, mq.size() == DEPTH);
        check("iss_id", iss_id, m_next_id);
        n = (rdy_in && !m_flush) ? m_ncommit() : 0;
        exp_valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        check("cm_valid", cm_valid, exp_valid);
        for (int k = 0; k < n; k++) begin
            check("cm_id", cm_id[k*ADDR_W +: ADDR_W], mq[k].id);
            check("cm_rd", cm_rd[k*5 +: 5], mq[k].rd);
            check("cm_value", cm_value[k*32 +: 32], mq[k].value);
            check("cm_wr", cm_wr[k], mq[k].typ inside {TYPE_TOREG, TYPE_LOAD, TYPE_JUMP});
        end
        check("lsb_head_valid", lsb_head_valid,
              mq.size() > 0 && (mq[0].typ inside {TYPE_LOAD, TYPE_STORE}));
        if (mq.size() > 0) check("lsb_head_id", lsb_head_id, mq[0].id);
        for (int j = 0; j < 2; j++) begin
            qid = int'(q_id[j*ADDR_W +: ADDR_W]);
            idx = m_find(qid);
            sr  = (idx >= 0) && mq[idx].rdy;
            hit = 1'b0;
            hv  = 32'd0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (!hit && wb_valid[p] && int'(wb_id[p*ADDR_W +: ADDR_W]) == qid) begin
                    hit = 1'b1;
                    hv  = wb_value[p*32 +: 32];
                end
            end
            check("q_ready", q_ready[j], sr | hit);
            check("q_value", q_value[j*32 +: 32], sr ? mq[idx].value : hv);
        end
        check("flush_out", flush_out, m_flush);
        check("bp_valid", bp_valid, m_bp_valid);
        check("exit_out", exit_out, m_exit);
        if (m_flush) check("flush_pc", flush_pc, m_flush_pc);
        if (m_bp_valid) begin
            check("bp_pc", bp_pc, m_bp_pc);
            check("bp_taken", bp_taken, m_bp_taken);
        end
    endtask

    task automatic m_step();
        int   n, pre;
        logic taken;
        ent_t h, e;
        if (!rdy_in) return;
        if (m_flush) begin
            m_reset();
            return;
        end
        n   = m_ncommit();
        pre = mq.size();
        m_bp_valid = 1'b0;
        m_flush    = 1'b0;
        m_exit     = 1'b0;
        if (n > 0) begin
            h = mq[0];
            if (h.typ == TYPE_BRANCH) begin
                taken      = (h.value != 32'd0);
                m_bp_valid = 1'b1;
                m_bp_pc    = h.pc;
                m_bp_taken = taken;
                if (taken != h.pred) begin
                    m_flush    = 1'b1;
                    m_flush_pc = taken ? h.target : h.pc + 32'd4;
                end
            end else if (h.typ == TYPE_JUMP && h.jalr) begin
                m_flush    = 1'b1;
                m_flush_pc = h.target;
            end else if (h.typ == TYPE_EXIT) begin
                m_exit = 1'b1;
            end
        end
        foreach (mq[i]) begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && int'(wb_id[p*ADDR_W +: ADDR_W]) == mq[i].id) begin
                    mq[i].rdy = 1'b1;
                    if (mq[i].jalr) mq[i].target = wb_value[p*32 +: 32];
                    else            mq[i].value  = wb_value[p*32 +: 32];
                    break;
                end
            end
        end
        repeat (n) void'(mq.pop_front());
        if (iss_valid && pre < DEPTH) begin
            e.typ = iss_type; e.jalr = iss_is_jalr; e.rd = iss_rd; e.value = iss_value;
            e.pc = iss_pc; e.target = iss_target; e.pred = iss_pred_taken;
            e.rdy = iss_done; e.id = m_next_id;
            mq.push_back(e);
            m_next_id = (m_next_id + 1) % DEPTH;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        rdy_in = 1'b1; iss_valid = 1'b0; iss_done = 1'b0; iss_type = TYPE_TOREG;
        iss_is_jalr = 1'b0; iss_rd = 5'd0; iss_value = 32'd0; iss_pc = 32'd0;
        iss_target = 32'd0; iss_pred_taken = 1'b0;
        wb_valid = '0; wb_id = '0; wb_value = '0; q_id = '0;
    endtask

    task automatic set_issue(input logic [2:0] t, input logic done, input logic jalr,
                             input logic [4:0] rd, input logic [31:0] value,
                             input logic [31:0] pc, input logic [31:0] target,
                             input logic pred);
        idle_inputs();
        iss_valid = 1'b1; iss_type = t; iss_done = done; iss_is_jalr = jalr;
        iss_rd = rd; iss_value = value; iss_pc = pc; iss_target = target;
        iss_pred_taken = pred;
    endtask

    task automatic tick();
        @(negedge clk_in);
        check_outputs();
        m_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        m_reset();
        check("rst_empty", rob_empty, 1'b1);
        check("rst_flush", {flush_out, bp_valid, bp_taken, exit_out}, 4'b0000);
        check("rst_flush_pc", flush_pc, 32'd0);
        check("rst_bp_pc", bp_pc, 32'd0);
        check("rst_iss_id", iss_id, 3'd0);
    endtask

    logic [2:0] rt;
    int         r;

    initial begin
        // Fill: eight non-done toreg entries
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(TYPE_TOREG, 1'b0, 1'b0, 5'(5 + i), 32'(i), 32'h1000 + 32'(4 * i), 32'd0, 1'b0);
            check("fill_iss_id", iss_id, i);
            tick();
        end
        check("fill_full", rob_full, 1'b1);
        set_issue(TYPE_TOREG, 1'b1, 1'b0, 5'd31, 32'hDEAD, 32'h2000, 32'd0, 1'b0);
        tick();
        check("full_reject", rob_full, 1'b1);

        // Dual commit of ids 0 and 1
        idle_inputs();
        wb_valid = 2'b11; wb_id = {3'd1, 3'd0}; wb_value = {32'h22, 32'h11};
        tick();
        idle_inputs();
        #1;
        check("dual_valid", cm_valid, 2'b11);
        check("dual_rd", cm_rd, {5'd6, 5'd5});
        check("dual_value", cm_value, {32'h22, 32'h11});
        tick();
        check("dual_head", lsb_head_id, 3'd2);
        check("dual_not_full", rob_full, 1'b0);

        // Same-cycle bypass through port 1
        idle_inputs();
        q_id = {3'd0, 3'd3};
        wb_valid = 2'b10; wb_id = {3'd3, 3'd0}; wb_value = {32'hABCD, 32'h0};
        #1;
        check("bypass_ready", q_ready[0], 1'b1);
        check("bypass_value", q_value[31:0], 32'hABCD);
        tick();

        // Branch mispredict: predicted taken, resolves not taken
        do_reset();
        set_issue(TYPE_BRANCH, 1'b0, 1'b0, 5'd0, 32'd0, 32'h100, 32'h500, 1'b1);
        tick();
        set_issue(TYPE_TOREG, 1'b1, 1'b0, 5'd7, 32'h77, 32'h104, 32'd0, 1'b0);
        tick();
        idle_inputs();
        wb_valid = 2'b01; wb_id = {3'd0, 3'd0}; wb_value = {32'd0, 32'd0};
        tick();
        idle_inputs();
        #1;
        check("mp_commit", cm_valid, 2'b01);
        tick();
        check("mp_flush", flush_out, 1'b1);
        check("mp_flush_pc", flush_pc, 32'h104);
        check("mp_taken", bp_taken, 1'b0);
        check("mp_bp_valid", bp_valid, 1'b1);
        check("mp_no_commit", cm_valid, 2'b00);
        tick();
        check("mp_empty", rob_empty, 1'b1);

        // Jalr: target by writeback, younger toreg discarded by the flush
        do_reset();
        set_issue(TYPE_JUMP, 1'b0, 1'b1, 5'd1, 32'h44, 32'h40, 32'd0, 1'b0);
        tick();
        set_issue(TYPE_TOREG, 1'b1, 1'b0, 5'd2, 32'h55, 32'h44, 32'd0, 1'b0);
        tick();
        idle_inputs();
        wb_valid = 2'b01; wb_id = {3'd0, 3'd0}; wb_value = {32'd0, 32'h2000};
        tick();
        idle_inputs();
        #1;
        check("jalr_commit", cm_valid, 2'b01);
        check("jalr_link", cm_value[31:0], 32'h44);
        tick();
        check("jalr_flush", flush_out, 1'b1);
        check("jalr_flush_pc", flush_pc, 32'h2000);
        check("jalr_discard", cm_valid, 2'b00);
        tick();
        check("jalr_empty", rob_empty, 1'b1);

        // Stall with a pending commit
        do_reset();
        set_issue(TYPE_TOREG, 1'b1, 1'b0, 5'd9, 32'h99, 32'h80, 32'd0, 1'b0);
        tick();
        idle_inputs();
        rdy_in = 1'b0;
        repeat (3) begin
            #1;
            check("stall_no_commit", cm_valid, 2'b00);
            tick();
            check("stall_hold", rob_empty, 1'b0);
        end
        rdy_in = 1'b1;
        #1;
        check("stall_release", cm_valid, 2'b01);
        check("stall_rd", cm_rd[4:0], 5'd9);
        tick();
        check("stall_empty", rob_empty, 1'b1);

        // Random traffic
        do_reset();
        repeat (3000) begin
            idle_inputs();
            rdy_in = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 9);
            rt = (r < 4) ? TYPE_TOREG : (r < 6) ? TYPE_LOAD : (r == 6) ? TYPE_STORE :
                 (r == 7) ? TYPE_BRANCH : (r == 8) ? TYPE_JUMP : TYPE_EXIT;
            iss_valid      = ($urandom_range(0, 2) != 0);
            iss_type       = rt;
            iss_done       = ($urandom_range(0, 3) == 0);
            iss_is_jalr    = (rt == TYPE_JUMP) && ($urandom_range(0, 1) == 1);
            iss_rd         = 5'($urandom);
            iss_value      = $urandom_range(0, 1) ? $urandom : 32'd0;
            iss_pc         = $urandom & 32'hFFFF_FFFC;
            iss_target     = $urandom & 32'hFFFF_FFFC;
            iss_pred_taken = 1'($urandom);
            for (int p = 0; p < NUM_WB; p++) begin
                wb_valid[p] = 1'($urandom);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_id[p*ADDR_W +: ADDR_W] = ADDR_W'(mq[$urandom_range(0, mq.size() - 1)].id);
                else
                    wb_id[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                wb_value[p*32 +: 32] = $urandom_range(0, 1) ? $urandom : 32'd0;
            end
            if ($urandom_range(0, 4) == 0) wb_id[2*ADDR_W-1:ADDR_W] = wb_id[ADDR_W-1:0];
            for (int j = 0; j < 2; j++) begin
                if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                    q_id[j*ADDR_W +: ADDR_W] = ADDR_W'(mq[$urandom_range(0, mq.size() - 1)].id);
                else
                    q_id[j*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer, successor to the single-commit RoB.
- Sits between Decoder (issue), ALU/LSB/other FUs (N writeback ports), RegFile (commit), LSB (head id), Predictor and IF (flush).
- Adds configurable depth, NUM_WB writeback ports, and up to COMMIT_W in-order commits per cycle.
- Adds a true occupancy counter, so all DEPTH entries are usable, plus an exit pulse.

Parameters:
- ADDR_W, 3, log2 of entry count; DEPTH = 2**ADDR_W.
- NUM_WB, 2, number of writeback ports.
- COMMIT_W, 2, maximum commits per cycle; legal values 1 or 2.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  reset; synchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state and gates cm_valid low.
- iss_valid  in  1  issue request.
- iss_done  in  1  entry already complete at issue.
- iss_type  in  3  toreg/load/store/branch/jump/exit code (const package).
- iss_is_jalr  in  1  jump whose target arrives by writeback.
- iss_rd  in  5  destination register.
- iss_value  in  32  initial value (link address for jal/jalr).
- iss_pc  in  32  instruction pc.
- iss_target  in  32  branch taken target.
- iss_pred_taken  in  1  predictor decision.
- iss_id  out  ADDR_W  id assigned to the issuing instruction (= tail).
- rob_full  out  1  count == DEPTH.
- rob_empty  out  1  count == 0.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_id  in  NUM_WB*ADDR_W  packed entry ids.
- wb_value  in  NUM_WB*32  result; for jalr entries this is the target address.
- q_id  in  2*ADDR_W  two operand queries.
- q_ready  out  2  entry ready, or completed this cycle.
- q_value  out  64  bypassed value.
- cm_valid  out  COMMIT_W  slot k commits this cycle.
- cm_wr  out  COMMIT_W  slot k writes RF (toreg/load/jump).
- cm_rd  out  COMMIT_W*5  destination register per slot.
- cm_id  out  COMMIT_W*ADDR_W  entry id per slot.
- cm_value  out  COMMIT_W*32  value per slot.
- lsb_head_valid  out  1  not empty, and head is a load or store.
- lsb_head_id  out  ADDR_W  head id.
- flush_out  out  1  registered mispredict pulse.
- flush_pc  out  32  restart pc.
- bp_valid  out  1  registered pulse: a branch committed.
- bp_pc  out  32  pc of that branch.
- bp_taken  out  1  resolved direction.
- exit_out  out  1  registered pulse: exit entry committed.

Behaviour:
- Reset (rst_n_in low at a clock edge): head = tail = count = 0; all busy/ready bits 0; all registered outputs 0.
- Per-entry storage: busy, ready, type, is_jalr, rd, value, pc, target, pred.
- Issue: accepted when rdy_in & iss_valid & !rob_full & !flush_out.
  - Write entry at tail; tail++ with wrap modulo DEPTH; busy = 1; ready = iss_done.
  - Full check uses the pre-commit count; a same-cycle commit does not admit an issue to a full ROB.
- Writeback, per port p with wb_valid[p]:
  - Entry is busy: ready = 1. Jalr entry: target = wb_value; otherwise value = wb_value.
  - Non-busy id: ignored.
  - Two ports hitting the same id: lower port index wins.
- Query: q_ready = ready[id] | any matching wb port this cycle. q_value priority: stored value, then lowest-index matching port, else 0.
- Commit slot 0: head busy & ready.
- Commit slot 1 (COMMIT_W = 2) requires all of:
  - slot 0 commits;
  - head+1 busy & ready;
  - slot-0 type not in {branch, jump, store, exit};
  - slot-1 type not in {store, exit}. Branch and jump in slot 1 are also disallowed; control and store entries only ever commit from slot 0.
- Commit bookkeeping: head += ncommit; count_next = count + issued - ncommit; committed entries clear busy/ready. Commit outputs are combinational from head state and gated by rdy_in.
- Branch commit, registered into the next cycle:
  - bp_valid = 1, bp_pc = pc, bp_taken = (value != 0).
  - Misprediction (taken != pred): flush_out = 1; flush_pc = taken ? target : pc+4.
- Jalr commit: flush_out = 1, flush_pc = target.
- Exit commit: exit_out = 1.
- All registered pulses drop to 0 in the next rdy_in cycle that has no such commit.
- Flush: when flush_out = 1 and rdy_in, the ROB behaves as reset — issue, writeback and commit that cycle are all ignored. flush_out itself clears in the same cycle.
- rdy_in low: every register holds, including the pulses.

Decomposition:
- const.v additions: type codes (toreg_, load_, store_, branch_, jump_, exit_), a macro for the RF-writing type set, default ADDR_W.
- Sub-module rob_query_bypass: combinational, one query against NUM_WB ports; instantiated twice.

Test Plan:
- Fill: issue 8 non-done toreg entries with no writeback -> rob_full = 1 after the 8th, iss_id sequence 0..7; 9th iss_valid is not accepted.
- Dual commit: ids 0 and 1 both ready, rd = 5/6, values 0x11/0x22 -> cm_valid = 2'b11, cm_rd = {6,5}; head = 2 and count down by 2 next cycle.
- Bypass: wb port 1 writes id 3 value 0xABCD while q_id0 = 3 -> q_ready[0] = 1, q_value[0] = 0xABCD in the same cycle.
- Mispredict: branch at pc 0x100, pred = 1, wb value 0 -> next cycle flush_out = 1, flush_pc = 0x104, bp_taken = 0; the cycle after, count = 0.
- Jalr: jalr id 0 with wb target 0x2000, followed by a ready toreg -> only slot 0 commits; flush_pc = 0x2000; the toreg is discarded by the flush.
- Stall: rdy_in low for 3 cycles while a commit is pending -> cm_valid = 0, head/count unchanged; commit occurs on the first rdy_in-high cycle.
